sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
- Framed serial-to-parallel receiver. It is the receiving end of the team's framed serial link, and its counterpart is the PISO serializer output of the universal shift register.
- It captures a start bit, n data bits, an optional even-parity bit and a stop bit into an n-bit word.
- It presents the word to downstream logic over a valid/rdy handshake, with parity, framing and overrun status.
- Bit timing comes from an external bit strobe `en`; there is no oversampling.

Parameters:
- n, 4, data word width in bits (n >= 2).
- PAR_EN, 1, 1 = a parity bit follows the data bits (even parity); 0 = no parity bit, and the frame goes straight to the stop bit.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- en  input  1  bit strobe; `sin` is sampled only on posedge clk with en=1.
- sin  input  1  serial line; idles high.
- msb_first  input  1  1 = first data bit is the MSB; 0 = first data bit is the LSB. Latched at the start bit.
- rdy  input  1  consumer ready.
- q  output  n  received data word.
- valid  output  1  q holds an unconsumed word.
- perr  output  1  parity error flag belonging to the current q.
- ferr  output  1  framing error pulse, one cycle wide.
- ovr  output  1  sticky overrun flag.
- busy  output  1  receiver is not in IDLE.

Behaviour:

Reset and general rules
- Reset (rst=0, asynchronous) forces: q=0, valid=0, perr=0, ferr=0, ovr=0, busy=0, state=IDLE, bit counter=0, shift register=0.
- Reset mid-frame discards the partial word. No output changes on reset release.
- Cycles with en=0 hold the FSM, the counter and the shift register. The handshake and ferr clearing still run every clk.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.

State transitions
- IDLE:
  - en=1 and sin=0 (start bit) → DATA, counter=0, latch msb_first.
  - en=1 and sin=1 → stay in IDLE.
- DATA, on each en=1:
  - Shift in sin. With msb_first latched =1: sr <= {sr[n-2:0], sin}. Otherwise: sr <= {sin, sr[n-1:1]}.
  - counter++.
  - After the n-th bit → PARITY if PAR_EN=1, else STOP.
- PARITY, on en=1:
  - Store pbad = (^sr) ^ sin. Odd total ones across data plus parity bit = error.
  - → STOP.
- STOP, on en=1:
  - sin=1 (good frame):
    - q <= sr, valid <= 1, perr <= pbad (forced 0 when PAR_EN=0).
    - If valid=1 and rdy=0 at this edge, set ovr <= 1. The new word overwrites q.
    - → IDLE.
  - sin=0 (bad frame):
    - ferr <= 1 for exactly one clk.
    - q, valid and perr are unchanged.
    - → WAIT_IDLE.
- WAIT_IDLE: en=1 and sin=1 → IDLE. A low line is not treated as a new start bit.

Outputs and handshake
- busy = (state != IDLE), registered together with the state.
- Handshake: valid=1 and rdy=1 at a posedge means the word is consumed. valid clears and ovr clears at that edge.
- Simultaneous consume and new-word load at the same edge: the load wins. valid stays 1 with the new q, and ovr is not set.
- Latency: valid rises on the clk edge that samples a good stop bit. From the start-bit sample edge that is n+2 en-strobes with PAR_EN=1, or n+1 with PAR_EN=0.
- Back-to-back frames are supported: a start bit may be sampled on the en strobe immediately after the stop bit.

Test Plan:
1. n=4, PAR_EN=1, en=1 every cycle, msb_first=1, rdy=1. sin: idle 1, then 0, 1, 0, 1, 1 (data), 1 (parity), 1 (stop). → q=4'b1011, valid high for 1 cycle, perr=0, busy high from the cycle after the start sample until the stop sample.
2. Same bit sequence with msb_first=0. → q=4'b1101, perr=0. Also toggle msb_first mid-frame → result unaffected.
3. Same as scenario 1 with parity bit 0. → q=4'b1011, valid=1, perr=1. The next good frame clears perr to 0.
4. Same as scenario 1 with stop bit 0 and sin held 0 for 3 more strobes, then 1. → ferr one-cycle pulse, valid stays 0, q unchanged, busy=1 until the strobe where sin=1.
5. rdy=0. Send frame 4'b1011, then frame 4'b0110 back-to-back. → after the second stop bit: q=4'b0110, valid=1, ovr=1. Then rdy=1 for 1 cycle → valid=0, ovr=0.
6. en pulsed every 3rd clk. Assert rst low after 2 data bits. → all outputs 0 immediately, with no clk needed. Release rst and send 4'b1001 with parity 0. → q=4'b1001, perr=0.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Framed serial-to-parallel receiver: start, n data bits, optional even parity, stop.
// Bit timing comes from the external strobe en; the word is offered on a valid/rdy handshake.
module sipo_frame_rx #(
  parameter int n      = 4,
  parameter bit PAR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sin,
  input  logic         msb_first,
  input  logic         rdy,
  output logic [n-1:0] q,
  output logic         valid,
  output logic         perr,
  output logic         ferr,
  output logic         ovr,
  output logic         busy
);

  localparam int CW = $clog2(n);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          msb;
  logic [n-1:0]  sr;
  logic          pbad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      msb   <= 1'b0;
      sr    <= '0;
      pbad  <= 1'b0;
      q     <= '0;
      valid <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ferr <= 1'b0;
      // Consume first; a word loaded on the same edge overrides valid below.
      if (valid && rdy) begin
        valid <= 1'b0;
        ovr   <= 1'b0;
      end
      if (en) begin
        case (state)
          IDLE: if (!sin) begin
            state <= DATA;
            busy  <= 1'b1;
            cnt   <= '0;
            msb   <= msb_first;
          end
          DATA: begin
            sr  <= msb ? {sr[n-2:0], sin} : {sin, sr[n-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(n-1)) state <= PAR_EN ? PARITY : STOP;
          end
          PARITY: begin
            pbad  <= (^sr) ^ sin;
            state <= STOP;
          end
          STOP: if (sin) begin
            q     <= sr;
            valid <= 1'b1;
            perr  <= PAR_EN ? pbad : 1'b0;
            if (valid && !rdy) ovr <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ferr  <= 1'b1;
            state <= WAIT_IDLE;
          end
          // A low line here is the tail of a broken frame, not a new start bit.
          WAIT_IDLE: if (sin) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (n=4, even parity): table of good frames plus
// hand-written sequences for framing error, overrun, load-vs-consume and async reset.
module tb_sipo_frame_rx;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, en, sin, msb_first, rdy;
  logic [N-1:0] q;
  logic         valid, perr, ferr, ovr, busy;

  int npass = 0;
  int ntot  = 0;

  sipo_frame_rx #(.n(N), .PAR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .msb_first(msb_first), .rdy(rdy),
    .q(q), .valid(valid), .perr(perr), .ferr(ferr), .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         msb;
    logic [N-1:0] bits;   // sent bits[N-1] first
    logic         par;
    logic         tog;    // toggle msb_first on every data bit
    logic [N-1:0] exp_q;
    logic         exp_perr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic m, input logic [N-1:0] bits, input logic par,
                            input logic stp, input logic r, input logic r_stop, input logic tog);
    en = 1'b1; sin = 1'b0; msb_first = m; rdy = r;
    step();
    chk("busy_start", busy, 1'b1);
    for (int i = N-1; i >= 0; i--) begin
      sin = bits[i];
      if (tog) msb_first = ~msb_first;
      step();
      chk("busy_data", busy, 1'b1);
    end
    sin = par;
    step();
    chk("busy_par", busy, 1'b1);
    sin = stp; rdy = r_stop;
    step();
  endtask

  task automatic strobe(input logic s);
    en = 1'b0;
    step();
    step();
    en = 1'b1; sin = s;
    step();
    en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{msb:1'b1, bits:4'b1011, par:1'b1, tog:1'b0, exp_q:4'b1011, exp_perr:1'b0};
    vecs[1] = '{msb:1'b0, bits:4'b1011, par:1'b1, tog:1'b1, exp_q:4'b1101, exp_perr:1'b0};
    vecs[2] = '{msb:1'b1, bits:4'b1011, par:1'b0, tog:1'b0, exp_q:4'b1011, exp_perr:1'b1};
    vecs[3] = '{msb:1'b1, bits:4'b0110, par:1'b0, tog:1'b0, exp_q:4'b0110, exp_perr:1'b0};
    vecs[4] = '{msb:1'b0, bits:4'b0001, par:1'b1, tog:1'b0, exp_q:4'b1000, exp_perr:1'b0};

    rst = 1'b0; en = 1'b0; sin = 1'b1; msb_first = 1'b1; rdy = 1'b1;
    step();
    step();
    chk("rst_q", q, 4'h0);
    chk("rst_flags", {valid, perr, ferr, ovr, busy}, 5'b0);
    rst = 1'b1;
    en = 1'b1;
    step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", valid, 1'b0);

    foreach (vecs[k]) begin
      send_frame(vecs[k].msb, vecs[k].bits, vecs[k].par, 1'b1, 1'b1, 1'b1, vecs[k].tog);
      chk("frame_q", q, vecs[k].exp_q);
      chk("frame_valid", valid, 1'b1);
      chk("frame_perr", perr, vecs[k].exp_perr);
      chk("frame_ferr_busy", {ferr, busy, ovr}, 3'b000);
      sin = 1'b1;
      step();
      chk("frame_consumed", valid, 1'b0);
    end

    // Bad stop bit, then a held-low line that must not restart a frame.
    send_frame(1'b1, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ferr_pulse", ferr, 1'b1);
    chk("ferr_valid", valid, 1'b0);
    chk("ferr_q_kept", q, 4'b1000);
    chk("ferr_busy", busy, 1'b1);
    sin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_ferr_low", ferr, 1'b0);
      chk("wait_busy", busy, 1'b1);
    end
    sin = 1'b1;
    step();
    chk("wait_exit_busy", busy, 1'b0);
    chk("wait_exit_valid", valid, 1'b0);

    // Overrun: two back-to-back frames with nobody consuming.
    send_frame(1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_first_q", q, 4'b1011);
    chk("ovr_first", {valid, ovr}, 2'b10);
    send_frame(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_second_q", q, 4'b0110);
    chk("ovr_set", {valid, ovr}, 2'b11);
    en = 1'b0; rdy = 1'b1;
    step();
    chk("ovr_cleared", {valid, ovr}, 2'b00);

    // Consume and load on the same edge: load wins, no overrun.
    send_frame(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lw_first", {valid, ovr}, 2'b10);
    send_frame(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lw_q", q, 4'b1111);
    chk("lw_valid_ovr", {valid, ovr}, 2'b10);
    en = 1'b0;
    step();
    chk("lw_consumed", valid, 1'b0);

    // Sparse strobes, async reset mid-frame, then a clean frame.
    rdy = 1'b0;
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    step();
    chk("sparse_hold_busy", busy, 1'b1);
    chk("sparse_q_before", q, 4'b1111);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_q", q, 4'h0);
    chk("async_rst_flags", {valid, perr, ferr, ovr, busy}, 5'b0);
    #2 rst = 1'b1;
    strobe(1'b0);
    chk("sparse_start_busy", busy, 1'b1);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    chk("sparse_pre_stop_valid", valid, 1'b0);
    strobe(1'b1);
    chk("sparse_q", q, 4'b1001);
    chk("sparse_flags", {valid, perr, ferr, ovr, busy}, 5'b10000);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
